// File: rtl/change_dispenser.sv
// Coin change dispenser: pays out an amount in 5rs units using 10rs/5rs hoppers.
// Define CHANGE_TIMEOUT_EN to enable the hopper acknowledge timeout and sticky FAULT state.
module change_dispenser #(
   parameter int unsigned INV_FULL = 15,
   parameter int unsigned TIMEOUT  = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] amount,
   input  logic       hop_ack,
   input  logic       refill,
   output logic       disp10,
   output logic       disp5,
   output logic       busy,
   output logic       done,
   output logic       short,
   output logic [3:0] rem,
   output logic [3:0] inv10,
   output logic [3:0] inv5,
   output logic       fault
);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_ISSUE10, S_WAIT10, S_ISSUE5, S_WAIT5, S_DONE, S_FAULT
   } state_t;

   localparam logic [3:0] C_FULL = 4'(INV_FULL);

   if (INV_FULL < 1 || INV_FULL > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
      $error("change_dispenser: INV_FULL must be 1..15 and TIMEOUT 1..255");
   end

   state_t     r_state, w_next;
   logic [3:0] r_rem, r_inv10, r_inv5;
   logic       w_timeout;

`ifdef CHANGE_TIMEOUT_EN
   logic [7:0] r_cnt;
   // Fires on the cycle the count of ack-less WAIT cycles would reach TIMEOUT.
   assign w_timeout = (({1'b0, r_cnt} + 9'd1) == 9'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (reset)
         r_cnt <= '0;
      else if (r_state == S_ISSUE10 || r_state == S_ISSUE5)
         r_cnt <= '0;
      else if ((r_state == S_WAIT10 || r_state == S_WAIT5) && !hop_ack)
         r_cnt <= r_cnt + 8'd1;
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (start) w_next = S_CHECK;
         S_CHECK: begin
            if (r_rem == 4'd0)                       w_next = S_DONE;
            else if (r_rem >= 4'd2 && r_inv10 != '0) w_next = S_ISSUE10;
            else if (r_inv5 != '0)                   w_next = S_ISSUE5;
            else                                     w_next = S_DONE;
         end
         S_ISSUE10: w_next = S_WAIT10;
         S_WAIT10: begin
            if (hop_ack)        w_next = S_CHECK;
            else if (w_timeout) w_next = S_FAULT;
         end
         S_ISSUE5:  w_next = S_WAIT5;
         S_WAIT5: begin
            if (hop_ack)        w_next = S_CHECK;
            else if (w_timeout) w_next = S_FAULT;
         end
         S_DONE:    w_next = S_IDLE;
         S_FAULT:   w_next = S_FAULT;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rem   <= '0;
         r_inv10 <= C_FULL;
         r_inv5  <= C_FULL;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start)
                  r_rem <= (amount > 4'd10) ? 4'd10 : amount;
               else if (refill) begin
                  r_inv10 <= C_FULL;
                  r_inv5  <= C_FULL;
               end
            end
            S_WAIT10: if (hop_ack) begin
               r_rem   <= r_rem - 4'd2;
               r_inv10 <= r_inv10 - 4'd1;
            end
            S_WAIT5: if (hop_ack) begin
               r_rem  <= r_rem - 4'd1;
               r_inv5 <= r_inv5 - 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign disp10 = (r_state == S_ISSUE10);
   assign disp5  = (r_state == S_ISSUE5);
   assign busy   = (r_state != S_IDLE);
   assign done   = (r_state == S_DONE);
   assign short  = (r_state == S_DONE) && (r_rem != 4'd0);
   assign rem    = r_rem;
   assign inv10  = r_inv10;
   assign inv5   = r_inv5;
`ifdef CHANGE_TIMEOUT_EN
   assign fault  = (r_state == S_FAULT);
`else
   assign fault  = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized self-checking bench for change_dispenser against a greedy payout model.
module tb_change_dispenser;
   localparam int FULL = 15;

   logic       clk = 1'b0;
   logic       reset, start, refill, hop_hw, hop_man, hop_ack;
   logic [3:0] amount;
   logic       disp10, disp5, busy, done, short, fault;
   logic [3:0] rem, inv10, inv5;

   assign hop_ack = hop_hw | hop_man;

   change_dispenser #(.INV_FULL(FULL), .TIMEOUT(200)) dut (
      .clk(clk), .reset(reset), .start(start), .amount(amount), .hop_ack(hop_ack),
      .refill(refill), .disp10(disp10), .disp5(disp5), .busy(busy), .done(done),
      .short(short), .rem(rem), .inv10(inv10), .inv5(inv5), .fault(fault)
   );

   always #5 clk = ~clk;

   int compared = 0, mismatched = 0;
   int m10, m5, exp_rem, exp_short;
   int coinq[$];
   int n10 = 0, n5 = 0, done_cnt = 0, last_rem = 0, last_short = 0;
   int ack_delay = 3;
   bit ack_en = 1'b1;

   task automatic chk(input string nm, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (!reset) begin
         int c;
         chk("excl", int'(disp10 & disp5), 0);
         chk("fault", int'(fault), 0);
         if (disp10 || disp5) begin
            c = disp10 ? 10 : 5;
            if (disp10) n10++; else n5++;
            if (coinq.size() == 0) chk("coin_extra", c, 0);
            else begin
               chk("coin", c, coinq[0]);
               void'(coinq.pop_front());
            end
         end
         if (done) begin
            done_cnt++;
            last_rem   = int'(rem);
            last_short = int'(short);
            chk("done_rem", int'(rem), exp_rem);
            chk("done_short", int'(short), exp_short);
            chk("done_coins_left", coinq.size(), 0);
         end
         if (!busy) begin
            chk("inv10", int'(inv10), m10);
            chk("inv5", int'(inv5), m5);
            chk("rem_idle", int'(rem), exp_rem);
            chk("done_idle", int'(done), 0);
         end
      end
   end

   // Hopper: acknowledges each dispense command ack_delay cycles later.
   initial begin
      hop_hw = 1'b0;
      forever begin
         @(negedge clk);
         if (ack_en && !reset && (disp10 || disp5)) begin
            repeat (ack_delay) @(posedge clk);
            #1 hop_hw = 1'b1;
            @(posedge clk);
            #1 hop_hw = 1'b0;
         end
      end
   end

   task automatic model_reset();
      m10 = FULL; m5 = FULL; exp_rem = 0; exp_short = 0;
      coinq.delete();
   endtask

   task automatic do_reset();
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      model_reset();
      #1 reset = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400 && busy; i++) @(posedge clk);
      if (busy) chk("idle_timeout", int'(busy), 0);
   endtask

   task automatic do_refill();
      wait_idle();
      @(posedge clk); #1 refill = 1'b1;
      @(posedge clk); #1 refill = 1'b0;
      m10 = FULL; m5 = FULL;
   endtask

   task automatic pay(input int a, input int d, input bit poke);
      int r, t10, t5, base;
      int q[$];
      wait_idle();
      ack_delay = d;
      amount = 4'(a);
      r = (a > 10) ? 10 : a;
      t10 = m10; t5 = m5;
      while (r > 0) begin
         if (r >= 2 && t10 > 0) begin q.push_back(10); r -= 2; t10--; end
         else if (t5 > 0)       begin q.push_back(5);  r -= 1; t5--;  end
         else break;
      end
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      m10 = t10; m5 = t5; exp_rem = r; exp_short = (r != 0) ? 1 : 0;
      base = done_cnt;
      if (poke && q.size() > 0) begin
         coinq = q;
         repeat (2) @(posedge clk);
         #1 start = 1'b1; refill = 1'b1; amount = 4'd10;
         @(posedge clk); #1 start = 1'b0; refill = 1'b0;
      end else
         coinq = q;
      for (int i = 0; i < 400 && done_cnt == base; i++) @(posedge clk);
      if (done_cnt == base) chk("done_seen", 0, 1);
      repeat (3) @(posedge clk);
      chk("done_once", done_cnt - base, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int s10, s5;
      reset = 1'b1; start = 1'b0; refill = 1'b0; amount = '0; hop_man = 1'b0;
      model_reset();
      do_reset();

      @(negedge clk);
      chk("rst_busy", int'(busy), 0);   chk("rst_done", int'(done), 0);
      chk("rst_d10", int'(disp10), 0);  chk("rst_d5", int'(disp5), 0);
      chk("rst_short", int'(short), 0); chk("rst_rem", int'(rem), 0);
      chk("rst_inv10", int'(inv10), 15); chk("rst_inv5", int'(inv5), 15);

      // Exact change of 35rs: three 10s and one 5.
      s10 = n10; s5 = n5;
      pay(7, 3, 1'b0);
      @(negedge clk);
      chk("exact_n10", n10 - s10, 3); chk("exact_n5", n5 - s5, 1);
      chk("exact_short", last_short, 0); chk("exact_rem", last_rem, 0);
      chk("exact_inv10", int'(inv10), 12); chk("exact_inv5", int'(inv5), 14);
      chk("model_inv10", m10, 12);

      // Second start and a refill during WAIT10 are both ignored.
      s10 = n10; s5 = n5;
      pay(2, 6, 1'b1);
      @(negedge clk);
      chk("busy_n10", n10 - s10, 1); chk("busy_n5", n5 - s5, 0);
      chk("busy_inv10", int'(inv10), 11); chk("busy_inv5", int'(inv5), 14);

      // Deplete 10s: 11 -> 6 -> 1 -> 0 (last payout then uses 8 fives).
      pay(10, 2, 1'b0); pay(10, 1, 1'b0); pay(10, 1, 1'b0);
      @(negedge clk);
      chk("depl_inv10", int'(inv10), 0); chk("depl_inv5", int'(inv5), 6);
      s10 = n10; s5 = n5;
      pay(4, 2, 1'b0);
      @(negedge clk);
      chk("depl_n5", n5 - s5, 4); chk("depl_n10", n10 - s10, 0);
      chk("depl_short", last_short, 0); chk("depl_inv5b", int'(inv5), 2);

      // Short payout with one 5 left.
      pay(1, 1, 1'b0);
      s5 = n5;
      pay(3, 2, 1'b0);
      chk("short_n5", n5 - s5, 1); chk("short_flag", last_short, 1);
      chk("short_rem", last_rem, 2);
      pay(5, 1, 1'b0);
      chk("empty_rem", last_rem, 5);

      // Zero amount and clamped amount.
      do_refill();
      s10 = n10; s5 = n5;
      pay(0, 1, 1'b0);
      chk("zero_disp", (n10 - s10) + (n5 - s5), 0); chk("zero_short", last_short, 0);
      s10 = n10;
      pay(13, 1, 1'b0);
      chk("clamp_n10", n10 - s10, 5); chk("clamp_rem", last_rem, 0);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0) do_refill();
         else pay(int'($urandom_range(0, 15)), int'($urandom_range(1, 4)),
                  ($urandom_range(0, 3) == 0));
      end

      // Reset in the middle of WAIT10 drops the pending coin.
      do_refill();
      ack_en = 1'b0;
      amount = 4'd2;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      coinq = '{10};
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      model_reset();
      #1 reset = 1'b0;
      @(negedge clk);
      chk("mid_busy", int'(busy), 0); chk("mid_inv10", int'(inv10), 15);
      chk("mid_inv5", int'(inv5), 15); chk("mid_rem", int'(rem), 0);
      s10 = n10;
      @(posedge clk); #1 hop_man = 1'b1;
      @(posedge clk); #1 hop_man = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_ack_busy", int'(busy), 0); chk("mid_ack_inv10", int'(inv10), 15);
      chk("mid_ack_n10", n10 - s10, 0);
      ack_en = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
